// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv (package)
// Brief    : Shared core constants and the fetch-to-decode packet type.
// Revision : 1.0
// ============================================================================
package riscv;

    localparam int          IMEM_ADDR_WIDTH = 10;
    localparam int          INSN_WIDTH      = 32;
    localparam logic [31:0] RESET_PC        = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]           pc;
        logic [INSN_WIDTH-1:0] insn;
    } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Two-entry packet FIFO; the head always sits in slot 0 so the
//            output is a plain register.
// Revision : 1.0
// ============================================================================
module fetch_fifo
    import riscv::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  fetch_pkt_t wdata,
    output logic [1:0] occ,
    output fetch_pkt_t head
);

    logic [1:0] r_occ;
    fetch_pkt_t r_slot [2];
    logic       w_pop;

    assign w_pop = pop && (r_occ != 2'd0);
    assign occ   = r_occ;
    assign head  = r_slot[0];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_occ <= 2'd0;
        end else begin
            case ({push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_slot[0] <= wdata;
                    else               r_slot[1] <= wdata;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_slot[0] <= r_slot[1];
                    r_occ     <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; new packet lands behind whatever remains
                    if (r_occ == 2'd1) begin
                        r_slot[0] <= wdata;
                    end else begin
                        r_slot[0] <= r_slot[1];
                        r_slot[1] <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && r_occ == 2'd2));
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch
// Brief    : Instruction fetch unit: PC, imem issue, kill and packet buffer.
// Revision : 1.0
// ============================================================================
module fetch #(
    parameter int          ADDR_WIDTH = riscv::IMEM_ADDR_WIDTH,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = riscv::RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [DATA_WIDTH-1:0] out_insn
);

    logic [31:0]           r_pc;
    logic                  r_inflight;
    logic [31:0]           r_inflight_pc;
    logic                  r_kill;
    logic [ADDR_WIDTH-1:0] r_addr_hold;

    logic [1:0]            w_occ;
    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_load;
    logic                  w_issue;
    riscv::fetch_pkt_t     w_wdata;
    riscv::fetch_pkt_t     w_head;

    assign w_pop   = out_valid && out_ready;
    assign w_push  = r_inflight && !r_kill;
    // Packets buffered plus the one still in flight after this cycle's pop
    assign w_load  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = !reset && !redirect_valid && (w_load < 3'd2);

    // imem has no enable, so the address is held between issues
    assign imem_addr = w_issue ? r_pc[ADDR_WIDTH+1:2] : r_addr_hold;

    assign w_wdata.pc   = r_inflight_pc;
    assign w_wdata.insn = imem_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
            r_kill        <= 1'b0;
            r_addr_hold   <= RESET_PC[ADDR_WIDTH+1:2];
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc & ~32'h3;
            r_kill     <= r_inflight;
            r_inflight <= 1'b0;
        end else begin
            r_kill     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + 32'd4;
                r_addr_hold   <= r_pc[ADDR_WIDTH+1:2];
            end
        end
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_valid),
        .wdata (w_wdata),
        .occ   (w_occ),
        .head  (w_head)
    );

    assign out_valid = (w_occ != 2'd0);
    assign out_pc    = w_head.pc;
    assign out_insn  = w_head.insn;

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch
// Brief    : Directed cycle table plus a random-backpressure stream check.
// Revision : 1.0
// ============================================================================
module tb_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_insn;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_insn       (out_insn)
    );

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [9:0]  eaddr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic ev, input logic [31:0] epc,
                       input logic [9:0] ea);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.eaddr = ea;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] insn_of(input logic [31:0] pc);
        return 32'hA000_0000 + {22'd0, pc[11:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_pc;
        int          pops;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;

        // Streaming, then 5-cycle stall starting at cycle 4
        add(0,0,0,1, 0,32'h00,10'h000);
        add(0,0,0,1, 0,32'h00,10'h001);
        add(0,0,0,1, 1,32'h00,10'h002);
        add(0,0,0,1, 1,32'h04,10'h003);
        for (int i = 0; i < 5; i++) add(0,0,0,0, 1,32'h08,10'h003);
        add(0,0,0,1, 1,32'h08,10'h004);
        add(0,0,0,1, 1,32'h0C,10'h005);
        add(0,0,0,1, 1,32'h10,10'h006);
        add(0,0,0,1, 1,32'h14,10'h007);
        add(1,0,0,1, 1,32'h18,10'h007);
        // Restart, redirect to 0x100 in cycle 6 with a request in flight
        add(0,0,0,1, 0,32'h00,10'h000);
        add(0,0,0,1, 0,32'h00,10'h001);
        add(0,0,0,1, 1,32'h00,10'h002);
        add(0,0,0,1, 1,32'h04,10'h003);
        add(0,0,0,1, 1,32'h08,10'h004);
        add(0,0,0,1, 1,32'h0C,10'h005);
        add(0,1,32'h100,1, 1,32'h10,10'h005);
        add(0,0,0,1, 0,32'h00,10'h040);
        add(0,0,0,1, 0,32'h00,10'h041);
        add(0,0,0,1, 1,32'h100,10'h042);
        add(0,0,0,1, 1,32'h104,10'h043);
        // Unaligned redirect, then back-to-back redirects
        add(0,1,32'h203,1, 1,32'h108,10'h043);
        add(0,0,0,1, 0,32'h00,10'h080);
        add(0,0,0,1, 0,32'h00,10'h081);
        add(0,0,0,1, 1,32'h200,10'h082);
        add(0,1,32'h40,1, 1,32'h204,10'h082);
        add(0,1,32'h80,1, 0,32'h00,10'h082);
        add(0,0,0,1, 0,32'h00,10'h020);
        add(0,0,0,1, 0,32'h00,10'h021);
        add(0,0,0,1, 1,32'h80,10'h022);
        add(0,0,0,1, 1,32'h84,10'h023);
        // Fill to two buffered, then reset
        add(0,0,0,0, 1,32'h88,10'h023);
        add(0,0,0,0, 1,32'h88,10'h023);
        add(1,0,0,0, 1,32'h88,10'h023);
        add(0,0,0,1, 0,32'h00,10'h000);
        add(0,0,0,1, 0,32'h00,10'h001);
        add(0,0,0,1, 1,32'h00,10'h002);
        // PC wrap through 2^32
        add(0,1,32'hFFFF_FFF8,1, 1,32'h04,10'h002);
        add(0,0,0,1, 0,32'h00,10'h3FE);
        add(0,0,0,1, 0,32'h00,10'h3FF);
        add(0,0,0,1, 1,32'hFFFF_FFF8,10'h000);
        add(0,0,0,1, 1,32'hFFFF_FFFC,10'h001);
        add(0,0,0,1, 1,32'h0000_0000,10'h002);
        add(0,0,0,1, 1,32'h0000_0004,10'h003);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset imem_addr", {22'd0, imem_addr}, 32'd0);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            reset          = vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            out_ready      = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("row%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
            check($sformatf("row%0d imem_addr", i), {22'd0, imem_addr}, {22'd0, vecs[i].eaddr});
            if (vecs[i].ev) begin
                check($sformatf("row%0d out_pc", i), out_pc, vecs[i].epc);
                check($sformatf("row%0d out_insn", i), out_insn, insn_of(vecs[i].epc));
            end
        end

        // Random backpressure against a sequential PC model
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h300; out_ready = 1'b0;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        exp_pc = 32'h300;
        pops   = 0;
        for (int i = 0; i < 10000; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (out_valid) begin
                check("stream out_pc", out_pc, exp_pc);
                check("stream out_insn", out_insn, insn_of(exp_pc));
                if (out_ready) begin
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
            end
            @(posedge clk); #1;
        end
        check("stream progress", {31'd0, pops >= 1000}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
